// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the byte memory: fetch (read-only)
// and load/store share one access at a time through an IDLE/ISSUE/WAIT/RESP FSM.
module mem_arbiter #(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  input  logic [2:0]  if_byte_num,
  output logic [31:0] if_data,
  output logic        if_done,
  output logic        if_err,
  input  logic        ls_en,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_byte_num,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        ls_err,
  output logic        mem_rd_en,
  output logic [31:0] mem_rd_addr,
  output logic [2:0]  mem_rd_byte_num,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_done,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [2:0]  mem_wr_byte_num,
  input  logic        mem_wr_done
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;   // 0 = fetch, 1 = load/store
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
  logic [2:0]  bn_q, bn_d;
  logic        win, done_sel, issue, act, resp;

  function automatic logic [2:0] sanitize(input logic [2:0] bn);
    case (bn)
      3'd0:                      return 3'd1;
      3'd1, 3'd2, 3'd3, 3'd4:    return bn;
      default:                   return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] bn);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(bn)) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bn_q       <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bn_q       <= bn_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign done_sel = we_q ? mem_wr_done : mem_rd_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bn_d       = bn_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    win        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_en || ls_en) begin
          // On a tie the requester not served last wins; a lone request always wins.
          win     = (if_en && ls_en) ? ~last_q : ls_en;
          gnt_d   = win;
          last_d  = win;
          we_d    = win & ls_we;
          addr_d  = win ? ls_addr : if_addr;
          bn_d    = sanitize(win ? ls_byte_num : if_byte_num);
          wdata_d = win ? ls_wdata : '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          if (!we_q) begin
            if (gnt_q) ls_rdata_d = mask_bytes(mem_rd_data, bn_q);
            else       if_data_d  = mask_bytes(mem_rd_data, bn_q);
          end
          state_d = S_RESP;
        end else if (cnt_q == 8'(WAIT_MAX)) begin
          err_d = 1'b1;
          if (gnt_q) ls_rdata_d = '0;
          else       if_data_d  = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign issue = (state_q == S_ISSUE);
  assign act   = issue || (state_q == S_WAIT);
  assign resp  = (state_q == S_RESP);

  assign mem_rd_en       = issue && !we_q;
  assign mem_wr_en       = issue && we_q;
  assign mem_rd_addr     = act ? addr_q  : '0;
  assign mem_rd_byte_num = act ? bn_q    : '0;
  assign mem_wr_addr     = act ? addr_q  : '0;
  assign mem_wr_byte_num = act ? bn_q    : '0;
  assign mem_wr_data     = act ? wdata_q : '0;

  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;
  assign if_done  = resp && !gnt_q;
  assign ls_done  = resp && gnt_q;
  assign if_err   = if_done && err_q;
  assign ls_err   = ls_done && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model that can be
// stalled to force timeouts.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_en = 1'b0, ls_en = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [2:0]  if_byte_num = '0, ls_byte_num = '0;
  logic [31:0] if_data, ls_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic        if_done, if_err, ls_done, ls_err, mem_rd_en, mem_wr_en;
  logic [2:0]  mem_rd_byte_num, mem_wr_byte_num;
  logic [31:0] mem_rd_data = 32'hDEADBEEF;
  logic        mem_rd_done, mem_wr_done;
  logic        stall = 1'b0;

  int n_vec = 0, n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0;
  logic        cap_rd_en, cap_wr_en;
  logic [31:0] cap_rd_addr, cap_wr_addr, cap_wr_data;
  logic [2:0]  cap_rd_bn, cap_wr_bn;

  mem_arbiter #(.WAIT_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .if_en(if_en), .if_addr(if_addr), .if_byte_num(if_byte_num),
    .if_data(if_data), .if_done(if_done), .if_err(if_err),
    .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_byte_num(ls_byte_num),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_byte_num(mem_rd_byte_num),
    .mem_rd_data(mem_rd_data), .mem_rd_done(mem_rd_done),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_byte_num(mem_wr_byte_num), .mem_wr_done(mem_wr_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_done <= 1'b0;
      mem_wr_done <= 1'b0;
    end else begin
      mem_rd_done <= mem_rd_en & ~stall;
      mem_wr_done <= mem_wr_en & ~stall;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en && mem_wr_en) both_cnt++;
    if (if_done || ls_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the FSM idle; returns at the negedge where done is seen.
  task automatic access(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [2:0] bn, input logic [31:0] wd, output int lat);
    lat = 0;
    if (is_ls) begin
      ls_en = 1'b1; ls_we = we; ls_addr = addr; ls_byte_num = bn; ls_wdata = wd;
    end else begin
      if_en = 1'b1; if_addr = addr; if_byte_num = bn;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      lat = c;
      if (c == 1) begin
        cap_rd_en = mem_rd_en; cap_wr_en = mem_wr_en;
        cap_rd_addr = mem_rd_addr; cap_rd_bn = mem_rd_byte_num;
        cap_wr_addr = mem_wr_addr; cap_wr_data = mem_wr_data; cap_wr_bn = mem_wr_byte_num;
      end
      if ((is_ls && ls_done) || (!is_ls && if_done)) break;
    end
    if (!((is_ls && ls_done) || (!is_ls && if_done))) chk("done_bound", 32'(lat), 32'hFFFF);
    if (is_ls) ls_en = 1'b0; else if_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int lat, rd0, wr0, d0, nrec;
    int    t_rec [4];
    logic  w_rec [4];

    #1;
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_dones", {if_done, if_err, ls_done, ls_err}, 0);
    chk("rst_data", if_data | ls_rdata, 0);
    @(negedge clk); rst = 1'b0;

    // single fetch
    rd0 = rd_cnt; wr0 = wr_cnt;
    access(0, 0, 32'h10, 3'd4, 0, lat);
    chk("fetch_lat", 32'(lat), 3);
    chk("fetch_data", if_data, 32'hDEADBEEF);
    chk("fetch_err", 32'(if_err), 0);
    chk("fetch_issue_en", 32'(cap_rd_en), 1);
    chk("fetch_issue_addr", cap_rd_addr, 32'h10);
    chk("fetch_issue_bn", 32'(cap_rd_bn), 4);
    @(negedge clk);
    chk("fetch_rd_cycles", 32'(rd_cnt - rd0), 1);
    chk("fetch_wr_cycles", 32'(wr_cnt - wr0), 0);
    chk("fetch_idle_addr", mem_rd_addr, 0);

    // loads with byte masking
    access(1, 0, 32'h20, 3'd2, 0, lat);
    chk("load2_data", ls_rdata, 32'h0000BEEF);
    chk("load2_lat", 32'(lat), 3);
    @(negedge clk);
    chk("load2_held", ls_rdata, 32'h0000BEEF);
    access(1, 0, 32'h24, 3'd0, 0, lat);
    chk("load0_data", ls_rdata, 32'h000000EF);
    chk("load0_issue_bn", 32'(cap_rd_bn), 1);
    @(negedge clk);
    access(1, 0, 32'h28, 3'd7, 0, lat);
    chk("load7_data", ls_rdata, 32'hDEADBEEF);
    chk("load7_issue_bn", 32'(cap_rd_bn), 4);
    chk("if_data_kept", if_data, 32'hDEADBEEF);
    @(negedge clk);

    // store
    rd0 = rd_cnt; wr0 = wr_cnt;
    access(1, 1, 32'h8, 3'd3, 32'h12345678, lat);
    chk("store_lat", 32'(lat), 3);
    chk("store_wr_en", 32'(cap_wr_en), 1);
    chk("store_wr_addr", cap_wr_addr, 32'h8);
    chk("store_wr_data", cap_wr_data, 32'h12345678);
    chk("store_wr_bn", 32'(cap_wr_bn), 3);
    chk("store_err", 32'(ls_err), 0);
    chk("store_rdata_kept", ls_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("store_rd_cycles", 32'(rd_cnt - rd0), 0);
    chk("store_wr_cycles", 32'(wr_cnt - wr0), 1);

    // timeout on fetch
    stall = 1'b1;
    access(0, 0, 32'h40, 3'd4, 0, lat);
    chk("tmo_lat", 32'(lat), 11);
    chk("tmo_err", 32'(if_err), 1);
    chk("tmo_data", if_data, 0);
    stall = 1'b0;
    @(negedge clk);
    chk("tmo_back_idle", {31'd0, if_done}, 0);
    access(0, 0, 32'h44, 3'd4, 0, lat);
    chk("tmo_recover_lat", 32'(lat), 3);
    chk("tmo_recover_err", 32'(if_err), 0);
    @(negedge clk);

    // contention from reset: ls, if, ls, if, four cycles apart
    do_reset();
    if_addr = 32'h100; if_byte_num = 3'd4;
    ls_addr = 32'h200; ls_byte_num = 3'd4; ls_we = 1'b0;
    if_en = 1'b1; ls_en = 1'b1;
    nrec = 0;
    for (int c = 1; c <= 40 && nrec < 4; c++) begin
      @(negedge clk);
      if (if_done || ls_done) begin
        t_rec[nrec] = c; w_rec[nrec] = ls_done; nrec++;
      end
    end
    if_en = 1'b0; ls_en = 1'b0;
    chk("cont_count", 32'(nrec), 4);
    for (int k = 0; k < 4 && k < nrec; k++) begin
      chk($sformatf("cont_time%0d", k), 32'(t_rec[k]), 32'(3 + 4*k));
      chk($sformatf("cont_who%0d", k), 32'(w_rec[k]), 32'((k % 2) == 0));
    end
    @(negedge clk);
    chk("never_both_en", 32'(both_cnt), 0);

    // async reset while waiting
    stall = 1'b1;
    ls_en = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_byte_num = 3'd4;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_addr", mem_rd_addr, 32'h300);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", mem_rd_addr, 0);
    chk("arst_rdata", ls_rdata, 0);
    chk("arst_if_data", if_data, 0);
    chk("arst_dones", {ls_done, if_done, mem_rd_en, mem_wr_en}, 0);
    ls_en = 1'b0; stall = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_done", 32'(done_cnt - d0), 0);
    access(0, 0, 32'h50, 3'd4, 0, lat);
    chk("post_rst_lat", 32'(lat), 3);
    chk("post_rst_data", if_data, 32'hDEADBEEF);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter placed directly upstream of the fake byte memory. It accepts level-held requests from instruction fetch (read-only) and load/store (read or write), grants one at a time under round-robin, and drives the memory's separate read and write ports. It guarantees the memory's read enable and write enable are never high together. It returns read data zero-masked to the requested byte count, with a one-cycle done pulse per request.

## Interface
Parameters:
- WAIT_MAX, 8: cycles allowed in WAIT for memory done before abort; legal range 1–255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- if_en  in  1  fetch request; held high until if_done.
- if_addr  in  32  fetch address.
- if_byte_num  in  3  bytes to read.
- if_data  out  32  fetch read data; valid while if_done=1, then held.
- if_done  out  1  one-cycle completion pulse.
- if_err  out  1  high with if_done when the access timed out.
- ls_en  in  1  load/store request; held high until ls_done.
- ls_we  in  1  1 = write, 0 = read; stable while ls_en=1.
- ls_addr  in  32  load/store address.
- ls_byte_num  in  3  bytes to transfer.
- ls_wdata  in  32  write data.
- ls_rdata  out  32  read data; valid while ls_done=1, then held.
- ls_done  out  1  one-cycle completion pulse.
- ls_err  out  1  high with ls_done on timeout.
- mem_rd_en, mem_rd_addr[32], mem_rd_byte_num[3]  out  memory read port request.
- mem_rd_data  in  32  memory read data.
- mem_rd_done  in  1  memory read completion.
- mem_wr_en, mem_wr_addr[32], mem_wr_data[32], mem_wr_byte_num[3]  out  memory write port request.
- mem_wr_done  in  1  memory write completion.

## Operation
- FSM states:
  - IDLE: sample if_en and ls_en; if any is high, latch winner, addr, byte_num, wdata, we → ISSUE.
  - ISSUE: exactly one cycle; assert mem_rd_en (fetch, or load/store with ls_we=0) or mem_wr_en (store), never both → WAIT.
  - WAIT: all mem enables low; count cycles; on selected done=1 → RESP, capturing mem_rd_data for reads; on count reaching WAIT_MAX → RESP with err=1 and data 0.
  - RESP: winner's done=1 (and err if set) for one cycle → IDLE.
- Arbitration: round-robin on a last_grant bit.
  - Both requests high in IDLE: grant the one not granted last.
  - Single request: grant it regardless of last_grant.
  - last_grant updates at ISSUE entry. After reset, last_grant = fetch, so load/store wins the first tie.
- Requests are not sampled in RESP. A requester must drop en in the cycle following done, or it is treated as a new request.
- byte_num sanitizing, applied when latching: 0 → 1; 5–7 → 4; 1–4 unchanged.
- Read data masking: bytes at index ≥ sanitized byte_num are forced to 0 before the result is presented.
- Write data is forwarded unmasked.
- mem_*_addr, mem_*_byte_num and mem_wr_data are driven from latched values in ISSUE and WAIT, and are 0 in IDLE.
- Non-granted requester outputs keep their previous data; done and err stay 0.

## Timing
- Reset (async, immediate):
  - state = IDLE, wait counter = 0, last_grant = fetch.
  - All outputs 0: mem_rd_en, mem_wr_en, mem_* address/data/byte_num, if_data, if_done, if_err, ls_rdata, ls_done, ls_err.
- Reset mid-access aborts it with no done pulse; a memory request already in flight is dropped.
- Best-case latency: request high in cycle 0 (IDLE) → mem en in cycle 1 → done seen in cycle 2 → requester done in cycle 3.
- Throughput: one access per 4 cycles, since IDLE is re-entered in cycle 4.
- Memory done is sampled only in WAIT; a done level already high before ISSUE is ignored during IDLE/ISSUE.
- Timeout: done absent for WAIT_MAX consecutive WAIT cycles → RESP on the next cycle.
  - Error response lands WAIT_MAX + 2 cycles after ISSUE.
- Simultaneous request arrival in IDLE is resolved by round-robin.
- A request arriving during another access waits; it is granted in the next IDLE.

## Test plan
- Single fetch: addr 0x10, byte_num 4, memory returns 0xDEADBEEF → mem_rd_en high for exactly cycle 1, if_done at cycle 3, if_data = 0xDEADBEEF, if_err = 0, mem_wr_en stays 0.
- Load with masking: ls_we=0, byte_num 2, memory data 0xDEADBEEF → ls_rdata = 0x0000BEEF; byte_num 0 → 0x000000EF; byte_num 7 → 0xDEADBEEF.
- Store: ls_we=1, addr 0x8, wdata 0x12345678, byte_num 3 → mem_wr_en one cycle with addr 0x8, data 0x12345678, byte_num 3; mem_rd_en never high; ls_done at cycle 3.
- Contention: if_en and ls_en held high from reset → grant order ls, if, ls, if; dones 4 cycles apart; mem_rd_en & mem_wr_en never both 1 on any edge.
- Timeout: WAIT_MAX = 8, mem_rd_done tied 0 → if_done and if_err at cycle 11, if_data = 0, FSM returns to IDLE.
- Async reset asserted in WAIT → all outputs 0 immediately, no done pulse; after release, a fresh request completes in 3 cycles.
